// File: rtl/led_scanner_pwm_if.sv
// Button, mode and LED-bargraph signals between the pad ring and the scanner.
interface led_scanner_pwm_if #(
   parameter int NUM_LEDS = 8
);
   logic                btn_pause;
   logic                btn_faster;
   logic                btn_slower;
   logic [1:0]          mode;
   logic [NUM_LEDS-1:0] led;
   logic [3:0]          pos_out;
   logic                dir_out;
   logic [2:0]          speed_out;
   logic                paused_out;

   modport master (
      output btn_pause, btn_faster, btn_slower, mode,
      input  led, pos_out, dir_out, speed_out, paused_out
   );

   modport slave (
      input  btn_pause, btn_faster, btn_slower, mode,
      output led, pos_out, dir_out, speed_out, paused_out
   );
endinterface

// File: rtl/led_scanner_pwm.sv
// LED scanner: debounced buttons, speed-scaled tick, moving PWM head with fading tail.
// Optional macro PAUSE_BLINK_EN: while paused, blink the head with acc MSB and blank the tail.
module led_scanner_pwm #(
   parameter int NUM_LEDS   = 8,
   parameter int PWM_BITS   = 8,
   parameter int DIV_BITS   = 24,
   parameter int SHIFT_BASE = 10,
   parameter int DB_BITS    = 18,
   parameter int TAIL       = 2
) (
   input logic               clk,
   input logic               rst_n,
   led_scanner_pwm_if.slave  bus
);
   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'b00,
      MODE_FWD    = 2'b01,
      MODE_REV    = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_e;

   localparam logic [3:0]          LAST = 4'(NUM_LEDS - 1);
   localparam logic [PWM_BITS-1:0] FULL = '1;

   mode_e md;
   assign md = mode_e'(bus.mode);

   // bit 0 pause, bit 1 faster, bit 2 slower
   logic [2:0]         raw, sync1, sync2, stable, stable_q, rise;
   logic [DB_BITS-1:0] db_cnt [3];

   assign raw  = {bus.btn_slower, bus.btn_faster, bus.btn_pause};
   assign rise = stable & ~stable_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_q <= '0;
         for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         stable_q <= stable;
         for (int b = 0; b < 3; b++) begin
            if (sync2[b] == stable[b]) begin
               db_cnt[b] <= '0;
            end else if (&db_cnt[b]) begin
               stable[b] <= sync2[b];
               db_cnt[b] <= '0;
            end else begin
               db_cnt[b] <= db_cnt[b] + DB_BITS'(1);
            end
         end
      end
   end

   logic [2:0] speed;
   logic       paused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         speed  <= 3'd3;
         paused <= 1'b1;
      end else begin
         if (rise[0]) paused <= ~paused;
         // simultaneous faster+slower edges cancel out
         if (rise[1] && !rise[2] && speed != 3'd7)      speed <= speed + 3'd1;
         else if (rise[2] && !rise[1] && speed != 3'd0) speed <= speed - 3'd1;
      end
   end

   logic [DIV_BITS-1:0] acc;
   logic [DIV_BITS:0]   acc_sum;
   logic                tick;

   assign acc_sum = {1'b0, acc} + ((DIV_BITS+1)'(1) << (int'(speed) + SHIFT_BASE));
   assign tick    = acc_sum[DIV_BITS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= '0;
      else        acc <= acc_sum[DIV_BITS-1:0];
   end

   logic [3:0] pos, pos_nxt;
   logic       dir, dir_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos <= '0;
         dir <= 1'b0;
      end else begin
         pos <= pos_nxt;
         dir <= dir_nxt;
      end
   end

   always_comb begin
      pos_nxt = pos;
      dir_nxt = dir;
      if (tick && !paused) begin
         if ({1'b0, pos} >= 5'(NUM_LEDS)) begin
            pos_nxt = '0;
         end else begin
            case (md)
               MODE_BOUNCE: begin
                  if (!dir && pos == LAST) begin
                     dir_nxt = 1'b1;
                     pos_nxt = pos - 4'd1;
                  end else if (dir && pos == 4'd0) begin
                     dir_nxt = 1'b0;
                     pos_nxt = pos + 4'd1;
                  end else begin
                     pos_nxt = dir ? pos - 4'd1 : pos + 4'd1;
                  end
               end
               MODE_FWD: begin
                  dir_nxt = 1'b0;
                  pos_nxt = (pos == LAST) ? 4'd0 : pos + 4'd1;
               end
               MODE_REV: begin
                  dir_nxt = 1'b1;
                  pos_nxt = (pos == 4'd0) ? LAST : pos - 4'd1;
               end
               default: begin
                  pos_nxt = pos;
                  dir_nxt = dir;
               end
            endcase
         end
      end
   end

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [NUM_LEDS-1:0] led_nxt, led_q;

   // Wrap distances add a multiple of NUM_LEDS so the modulo operand never goes negative.
   always_comb begin
      int                  d;
      int                  p;
      logic [PWM_BITS-1:0] br;
      d       = 0;
      p       = int'(pos);
      br      = '0;
      led_nxt = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         case (md)
            MODE_FWD: d = (p - i + 16*NUM_LEDS) % NUM_LEDS;
            MODE_REV: d = (i - p + 16*NUM_LEDS) % NUM_LEDS;
            default:  d = (i > p) ? i - p : p - i;
         endcase
         br         = (d <= TAIL) ? (FULL >> (2*d)) : '0;
         led_nxt[i] = (pwm_cnt < br);
`ifdef PAUSE_BLINK_EN
         if (paused) led_nxt[i] = (d == 0) ? (led_nxt[i] & acc[DIV_BITS-1]) : 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         led_q   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         led_q   <= led_nxt;
      end
   end

   assign bus.led        = led_q;
   assign bus.pos_out    = pos;
   assign bus.dir_out    = dir;
   assign bus.speed_out  = speed;
   assign bus.paused_out = paused;

endmodule

// File: tb/tb_led_scanner_pwm.sv
// Scoreboarded bench: stimulus queues expected head moves / speed / pause changes, a monitor pops them.
module tb_led_scanner_pwm;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   led_scanner_pwm_if #(.NUM_LEDS(8)) bus ();

   led_scanner_pwm #(
      .NUM_LEDS(8), .PWM_BITS(8), .DIV_BITS(8), .SHIFT_BASE(0), .DB_BITS(2), .TAIL(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [3:0] pos;
      logic       dir;
      int         gap;
   } mv_t;

   mv_t        mv_q[$];
   logic [2:0] sp_q[$];
   logic       ps_q[$];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // gap 0 = interval not checked (first move after a pause/mode change/reset)
   task automatic push_mv(input int p, input int d, input int g);
      mv_t m;
      m.pos = 4'(p);
      m.dir = 1'(d);
      m.gap = g;
      mv_q.push_back(m);
   endtask

   task automatic wait_empty(input string nm, input int budget);
      int n = 0;
      while ((mv_q.size() + sp_q.size() + ps_q.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(nm, mv_q.size() + sp_q.size() + ps_q.size(), 0);
   endtask

   // 0 pause, 1 faster, 2 slower, 3 faster+slower together
   task automatic press(input int which);
      @(negedge clk);
      bus.btn_pause  = (which == 0);
      bus.btn_faster = (which == 1 || which == 3);
      bus.btn_slower = (which == 2 || which == 3);
      repeat (10) @(negedge clk);
      bus.btn_pause  = 1'b0;
      bus.btn_faster = 1'b0;
      bus.btn_slower = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic count_leds(input string nm, input int e [8]);
      int cnt [8];
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      repeat (256) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) cnt[i] += int'(bus.led[i]);
      end
      for (int i = 0; i < 8; i++) chk($sformatf("%s_led%0d", nm, i), cnt[i], e[i]);
   endtask

   initial begin
      mv_t        m;
      logic [3:0] lp;
      logic [2:0] ls;
      logic       lpa;
      int         cyc;
      int         lc;
      wait (mon_en);
      lp  = 4'd0;
      ls  = 3'd3;
      lpa = 1'b1;
      cyc = 0;
      lc  = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.pos_out !== lp) begin
            if (mv_q.size() == 0) begin
               chk("pos_unexpected", int'(bus.pos_out), int'(lp));
            end else begin
               m = mv_q.pop_front();
               chk("pos", int'(bus.pos_out), int'(m.pos));
               chk("dir", int'(bus.dir_out), int'(m.dir));
               if (m.gap != 0) chk("tick_gap", cyc - lc, m.gap);
            end
            lp = bus.pos_out;
            lc = cyc;
         end
         if (bus.speed_out !== ls) begin
            if (sp_q.size() == 0) chk("speed_unexpected", int'(bus.speed_out), int'(ls));
            else                  chk("speed", int'(bus.speed_out), int'(sp_q.pop_front()));
            ls = bus.speed_out;
         end
         if (bus.paused_out !== lpa) begin
            if (ps_q.size() == 0) chk("paused_unexpected", int'(bus.paused_out), int'(lpa));
            else                  chk("paused", int'(bus.paused_out), int'(ps_q.pop_front()));
            lpa = bus.paused_out;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.btn_pause  = 1'b0;
      bus.btn_faster = 1'b0;
      bus.btn_slower = 1'b0;
      bus.mode       = 2'b00;
      repeat (4) @(negedge clk);
      chk("rst_led", int'(bus.led), 0);
      chk("rst_pos", int'(bus.pos_out), 0);
      chk("rst_dir", int'(bus.dir_out), 0);
      chk("rst_speed", int'(bus.speed_out), 3);
      chk("rst_paused", int'(bus.paused_out), 1);
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);

      // 2-cycle glitch must be rejected by the debouncer
      bus.btn_pause = 1'b1;
      repeat (2) @(negedge clk);
      bus.btn_pause = 1'b0;
      repeat (12) @(negedge clk);
      chk("glitch_paused", int'(bus.paused_out), 1);

      // unpause and scan a full bounce cycle
      ps_q.push_back(1'b0);
      push_mv(1, 0, 0);
      for (int p = 2; p <= 7; p++) push_mv(p, 0, 32);
      for (int p = 6; p >= 0; p--) push_mv(p, 1, 32);
      push_mv(1, 0, 32);
      bus.btn_pause = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("pause_latency", int'(bus.paused_out), 0);
      @(negedge clk);
      repeat (4) @(negedge clk);
      bus.btn_pause = 1'b0;
      wait_empty("bounce_scan", 800);

      ps_q.push_back(1'b1);
      press(0);

      for (int s = 4; s <= 7; s++) sp_q.push_back(3'(s));
      repeat (5) press(1);
      chk("speed_sat_hi", int'(bus.speed_out), 7);
      press(3);
      chk("speed_both", int'(bus.speed_out), 7);
      for (int s = 6; s >= 0; s--) sp_q.push_back(3'(s));
      repeat (8) press(2);
      chk("speed_sat_lo", int'(bus.speed_out), 0);
      for (int s = 1; s <= 3; s++) sp_q.push_back(3'(s));
      repeat (3) press(1);
      wait_empty("speed_seq", 50);

      // walk to pos 6, then wrap-forward, wrap-reverse, freeze
      ps_q.push_back(1'b0);
      push_mv(2, 0, 0);
      for (int p = 3; p <= 6; p++) push_mv(p, 0, 32);
      press(0);
      wait_empty("to_pos6", 300);
      bus.mode = 2'b01;
      push_mv(7, 0, 32); push_mv(0, 0, 32); push_mv(1, 0, 32);
      wait_empty("wrap_fwd", 200);
      bus.mode = 2'b10;
      push_mv(0, 1, 32); push_mv(7, 1, 32); push_mv(6, 1, 32);
      wait_empty("wrap_rev", 200);
      bus.mode = 2'b11;
      repeat (110) @(negedge clk);
      chk("freeze_pos", int'(bus.pos_out), 6);
      chk("freeze_dir", int'(bus.dir_out), 1);

      // bounce down to pos 3, pause, measure PWM duty
      bus.mode = 2'b00;
      push_mv(5, 1, 0); push_mv(4, 1, 32); push_mv(3, 1, 32);
      wait_empty("to_pos3", 200);
      ps_q.push_back(1'b1);
      press(0);
      count_leds("bounce3", '{0, 15, 63, 255, 63, 15, 0, 0});

      bus.mode = 2'b01;
      ps_q.push_back(1'b0);
      push_mv(4, 0, 0);
      for (int p = 5; p <= 7; p++) push_mv(p, 0, 32);
      push_mv(0, 0, 32);
      press(0);
      wait_empty("to_pos0", 300);
      ps_q.push_back(1'b1);
      press(0);
      count_leds("fwd0", '{255, 0, 0, 0, 0, 0, 15, 63});
      bus.mode = 2'b10;
      count_leds("rev0", '{255, 63, 15, 0, 0, 0, 0, 0});

      // reset in the middle of a scan at pos 5
      bus.mode = 2'b00;
      ps_q.push_back(1'b0);
      push_mv(1, 0, 0);
      for (int p = 2; p <= 5; p++) push_mv(p, 0, 32);
      press(0);
      wait_empty("to_pos5", 300);
      push_mv(0, 0, 0);
      ps_q.push_back(1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_led", int'(bus.led), 0);
      chk("mid_rst_pos", int'(bus.pos_out), 0);
      chk("mid_rst_speed", int'(bus.speed_out), 3);
      chk("mid_rst_paused", int'(bus.paused_out), 1);
      repeat (3) @(negedge clk);
      chk("mid_rst_led_hold", int'(bus.led), 0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_pos", int'(bus.pos_out), 0);
      wait_empty("final_queues", 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/led_scanner_pwm.md
Name: led_scanner_pwm

Overview:
Parametrised LED scanner for the TT bargraph outputs, driving NUM_LEDS LEDs with a moving PWM-dimmed head and a fading tail.
- Inputs: three raw push-buttons (pause, faster, slower), each synchronised and debounced inside the block.
- Mode select: bounce, wrap-forward, wrap-reverse and freeze.
- Sits directly between ui_in buttons and uo_out LEDs in the top level.

Parameters:
NUM_LEDS, 8, number of LED outputs (2..16)
PWM_BITS, 8, PWM counter width; full brightness = 2^PWM_BITS-1
DIV_BITS, 24, speed accumulator width
SHIFT_BASE, 10, accumulator step exponent at speed 0; require SHIFT_BASE+7 < DIV_BITS
DB_BITS, 18, debounce counter width
TAIL, 2, tail length in LEDs (0..3)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
btn_pause  in  1  raw pause/run toggle button
btn_faster  in  1  raw speed-up button
btn_slower  in  1  raw slow-down button
mode  in  2  00 bounce, 01 wrap-forward, 10 wrap-reverse, 11 freeze
led  out  NUM_LEDS  PWM LED drive, active high
pos_out  out  4  current head position
dir_out  out  1  0 = up, 1 = down
speed_out  out  3  speed level, 0 slowest, 7 fastest
paused_out  out  1  1 = paused

Behaviour:
- Reset values (all asynchronous on rst_n low): pos=0, dir=0, speed=3, paused=1, accumulator=0, pwm counter=0, debounce counters=0, synchroniser flops=0, stable button states=0, led=0.
- Input conditioning: each button passes through a 2-flop synchroniser, then a debouncer.
  - Debouncer counter clears when sync==stable; otherwise it increments.
  - When the counter is all-ones and sync!=stable, stable<=sync and the counter clears.
- Edge detection: rising edges are detected on debounced stable signals only, against a registered previous stable value.
- Pause: a rising edge on pause toggles paused.
- Speed:
  - A faster edge increments speed, saturating at 7.
  - A slower edge decrements speed, saturating at 0.
  - Faster and slower edges in the same cycle: no change.
- Tick generator:
  - acc <= acc + (1 << (speed+SHIFT_BASE)), DIV_BITS wide; it runs even while paused.
  - tick = carry-out of that addition (one-cycle pulse).
  - Tick period is 2^(DIV_BITS-SHIFT_BASE-speed) cycles.
- Movement happens on tick && !paused only:
  - bounce: dir=0 and pos=NUM_LEDS-1 -> dir=1, pos-1. dir=1 and pos=0 -> dir=0, pos+1. Otherwise pos +/- 1 per dir.
  - wrap-forward: pos = (pos+1) mod NUM_LEDS; dir forced 0.
  - wrap-reverse: pos = (pos-1) mod NUM_LEDS; dir forced 1.
  - freeze: pos and dir hold.
  - A mode change is sampled each tick; there is no other side effect. Entering bounce keeps the current dir.
  - If pos >= NUM_LEDS, it is forced to 0 on the next tick (defensive).
- Brightness: d = distance of LED i from the head, bright(d) = FULL >> (2*d) for d <= TAIL, else 0.
  - bounce/freeze: d = |i-pos|, both sides, no wrap.
  - wrap-forward: d = (pos-i) mod NUM_LEDS (trailing only).
  - wrap-reverse: d = (i-pos) mod NUM_LEDS (trailing only).
- PWM:
  - pwm counter free-runs modulo 2^PWM_BITS.
  - led[i] = (pwm_cnt < bright[i]), registered, so led lags pwm_cnt by one cycle.
  - bright=0 gives constant 0.
- Paused (macro off): pattern frozen but PWM continues.
- Reset mid-operation: all state returns to reset values immediately; led=0 while rst_n low.

Optional Feature:
Macro PAUSE_BLINK_EN.
- Defined: while paused, the head LED output is additionally ANDed with acc[DIV_BITS-1] (visible blink) and tail LEDs are forced 0. Running behaviour is unchanged.
- Undefined: the paused display is the frozen full head+tail pattern.

Test Plan:
- Reset, DB_BITS=2: led=0, pos_out=0, speed_out=3, paused_out=1. btn_pause high 12 cycles -> paused_out=0 within 2+4+2 cycles of assertion. A 2-cycle glitch on btn_pause -> paused_out unchanged.
- DIV_BITS=8, SHIFT_BASE=0, speed 3 -> tick every 32 cycles. Bounce, NUM_LEDS=8: pos sequence 0,1..7,6..0,1 with dir_out changing at 7 and 0.
- Five faster presses -> speed_out 4,5,6,7,7 (saturates). Faster and slower edges in the same cycle -> speed_out unchanged. Eight slower presses -> 0.
- mode=01 from pos 6 -> 7,0,1 and dir_out=0. mode=10 -> 0,7,6 and dir_out=1. mode=11 -> pos holds across 3 ticks.
- PWM_BITS=8, TAIL=2, pos=3, bounce: over 256 cycles LED3 high 255, LEDs 2/4 high 63, LEDs 1/5 high 15, others 0. Wrap-forward pos=0: LEDs 7 and 6 lit, LED1 off.
- rst_n pulsed low mid-scan at pos=5 -> outputs immediately at reset values. With PAUSE_BLINK_EN: paused head toggles with acc MSB, tail LEDs 0.
